// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for a weight-stationary systolic MAC array
module systolic_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int PIPE_LAT   = 16,
    parameter int VEC_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [VEC_W-1:0]              cfg_num_vecs,
    output logic                          busy,
    output logic                          done,
    output logic                          w_rd_en,
    output logic [$clog2(ARRAY_SIZE)-1:0] w_rd_addr,
    output logic [ARRAY_SIZE-1:0]         pe_load_weight,
    output logic                          pe_enable,
    output logic                          pe_clear_acc,
    output logic                          act_zero,
    input  logic                          act_valid,
    output logic                          act_ready,
    output logic                          res_valid
);
    localparam int AW   = $clog2(ARRAY_SIZE);
    localparam int CMAX = (ARRAY_SIZE + 1 > PIPE_LAT) ? ARRAY_SIZE + 1 : PIPE_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0]         LOAD_LAST = CW'(ARRAY_SIZE);
    localparam logic [CW-1:0]         PIPE_LAST = CW'(PIPE_LAT - 1);
    localparam logic [ARRAY_SIZE-1:0] ROW0      = ARRAY_SIZE'(1);
    localparam logic [PIPE_LAT-1:0]   TAG_IN    = PIPE_LAT'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_FLUSH, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VEC_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic [VEC_W-1:0]    num_vecs_q, num_vecs_d;
    logic [PIPE_LAT-1:0] tag_q, tag_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            vec_cnt_q  <= '0;
            num_vecs_q <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            num_vecs_q <= num_vecs_d;
            tag_q      <= tag_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vec_cnt_d      = vec_cnt_q;
        num_vecs_d     = num_vecs_q;
        tag_d          = tag_q;
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        w_rd_en        = 1'b0;
        w_rd_addr      = '0;
        pe_load_weight = '0;
        pe_enable      = 1'b0;
        pe_clear_acc   = 1'b0;
        act_zero       = 1'b0;
        act_ready      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    num_vecs_d = cfg_num_vecs;
                    cnt_d      = '0;
                    vec_cnt_d  = '0;
                    state_d    = (cfg_num_vecs == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                // Row i-1 is loaded one cycle after its read because of buffer latency.
                if (cnt_q < LOAD_LAST) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = cnt_q[AW-1:0];
                end
                if (cnt_q != '0) begin
                    pe_load_weight = ROW0 << (cnt_q - CW'(1));
                end
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                pe_enable    = 1'b1;
                pe_clear_acc = 1'b1;
                act_zero     = 1'b1;
                tag_d        = '0;
                if (cnt_q == PIPE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STREAM: begin
                act_ready = 1'b1;
                pe_enable = act_valid;
                if (act_valid) begin
                    tag_d = (tag_q << 1) | TAG_IN;
                    if (vec_cnt_q != '1) begin
                        vec_cnt_d = vec_cnt_q + VEC_W'(1);
                    end
                    if (vec_cnt_q == num_vecs_q - VEC_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pe_enable = 1'b1;
                act_zero  = 1'b1;
                tag_d     = tag_q << 1;
                if (cnt_q == PIPE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            vec_cnt_d = '0;
            tag_d     = '0;
        end

        res_valid = pe_enable && tag_q[PIPE_LAT-1];
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - randomized self-checking bench for systolic_ctrl
module tb_systolic_ctrl;
    localparam int AS   = 4;
    localparam int PL   = 16;
    localparam int VW   = 16;
    localparam int AW   = $clog2(AS);
    localparam int OW   = 8 + AW + AS;
    localparam int MAXL = 66000;
    localparam int T0   = AS + 2 + PL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          act_valid = 1'b0;
    logic [VW-1:0] cfg_num_vecs = '0;
    logic          busy, done, w_rd_en, pe_enable, pe_clear_acc, act_zero, act_ready, res_valid;
    logic [AW-1:0] w_rd_addr;
    logic [AS-1:0] pe_load_weight;

    int compared = 0;
    int mismatched = 0;

    bit            av    [MAXL];
    bit            e_res [MAXL];
    logic [OW-1:0] obs   [MAXL];
    logic [OW-1:0] exp_o [MAXL];

    wire [OW-1:0] dut_o = {busy, done, w_rd_en, w_rd_addr, pe_load_weight,
                           pe_enable, pe_clear_acc, act_zero, act_ready, res_valid};

    systolic_ctrl #(.ARRAY_SIZE(AS), .PIPE_LAT(PL), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_num_vecs(cfg_num_vecs), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .pe_load_weight(pe_load_weight),
        .pe_enable(pe_enable), .pe_clear_acc(pe_clear_acc), .act_zero(act_zero),
        .act_valid(act_valid), .act_ready(act_ready), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] mk(bit b, bit d, bit we, int addr, int load,
                                         bit en, bit clr, bit z, bit rdy, bit r);
        return {b, d, we, AW'(addr), AS'(load), en, clr, z, rdy, r};
    endfunction

    // Phases are derived from the job timeline; results land PL enable cycles after acceptance.
    task automatic run_job(input int n, input int mode, input int cut_kind,
                           input int cut_at, input int restart_at, input string name);
        int t0, acc, an, dn, len, j, first_bad, exp_res, got_res, exp_dn, got_dn, done_at, i;
        int enl[$];
        bit b, we, en, clr, z, rdy;
        int addr, load;
        t0 = T0; acc = 0; an = -1; j = 0;
        while (j < MAXL - 200) begin
            case (mode)
                0:       av[j] = 1'b1;
                1:       av[j] = (j >= t0) ? ((j - t0) % 2 == 0) : 1'($urandom_range(0, 1));
                default: av[j] = ($urandom_range(0, 9) < 7);
            endcase
            if (n > 0 && j >= t0 && av[j] && acc < n) begin
                acc++;
                enl.push_back(j);
                if (acc == n) an = j;
            end
            j++;
            if (n == 0 || an >= 0) break;
        end
        dn  = (n == 0) ? 1 : an + PL + 1;
        len = (cut_at >= 0) ? cut_at + PL + 8 : dn + 3;
        for (int k = j; k <= len; k++) av[k] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (n > 0) for (int k = an + 1; k <= an + PL; k++) enl.push_back(k);
        for (int k = 0; k <= len; k++) e_res[k] = 1'b0;
        for (int k = 0; k < n; k++) e_res[enl[k + PL]] = 1'b1;
        exp_res = 0; exp_dn = 0;
        for (int k = 0; k <= len; k++) begin
            b = (k >= 1 && k <= dn);
            we = 0; addr = 0; load = 0; en = 0; clr = 0; z = 0; rdy = 0;
            if (n > 0) begin
                if (k >= 1 && k <= AS + 1) begin
                    i = k - 1;
                    if (i < AS) begin we = 1; addr = i; end
                    if (i >= 1) load = 1 << (i - 1);
                end else if (k >= AS + 2 && k < t0) begin
                    en = 1; clr = 1; z = 1;
                end else if (k >= t0 && k <= an) begin
                    rdy = 1; en = av[k];
                end else if (k > an && k <= an + PL) begin
                    en = 1; z = 1;
                end
            end
            if (cut_at >= 0 && k > cut_at) exp_o[k] = '0;
            else exp_o[k] = mk(b, k == dn, we, addr, load, en, clr, z, rdy, e_res[k]);
            exp_res += int'(exp_o[k][0]);
            exp_dn  += int'(exp_o[k][OW-2]);
        end

        for (int k = 0; k <= len; k++) begin
            start        = (k == 0) || (k == restart_at);
            cfg_num_vecs = (k == 0) ? VW'(n) : VW'($urandom);
            abort        = (cut_kind == 1 && k == cut_at);
            rst_n        = !(cut_kind == 2 && k == cut_at);
            act_valid    = av[k];
            @(negedge clk);
            obs[k] = dut_o;
            @(posedge clk);
            #1;
        end
        start = 0; abort = 0; rst_n = 1; act_valid = 0;

        first_bad = -1; got_res = 0; got_dn = 0; done_at = -1;
        for (int k = 0; k <= len; k++) begin
            if (first_bad < 0 && obs[k] !== exp_o[k]) first_bad = k;
            got_res += int'(obs[k][0] === 1'b1);
            got_dn  += int'(obs[k][OW-2] === 1'b1);
            if (done_at < 0 && obs[k][OW-2] === 1'b1) done_at = k;
        end
        compared++;
        if (first_bad >= 0) begin
            mismatched++;
            $display("FAIL %s timeline: cycle %0d got %h expected %h", name, first_bad,
                     obs[first_bad], exp_o[first_bad]);
        end
        compared++;
        if (got_res !== exp_res) begin
            mismatched++;
            $display("FAIL %s res_count: got %0d expected %0d", name, got_res, exp_res);
        end
        compared++;
        if (got_dn !== exp_dn) begin
            mismatched++;
            $display("FAIL %s done_count: got %0d expected %0d", name, got_dn, exp_dn);
        end
        if (mode == 0 && cut_at < 0) begin
            compared++;
            if (done_at !== (1 + AS + 1 + PL + n + PL + 1) - 1) begin
                mismatched++;
                $display("FAIL %s latency: got %0d expected %0d", name, done_at,
                         (1 + AS + 1 + PL + n + PL + 1) - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (dut_o !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected %h", dut_o, {OW{1'b0}});
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_basic();        run_job(3, 0, 0, -1, -1, "basic_n3");        endtask
    task automatic test_stall_toggle(); run_job(4, 1, 0, -1, -1, "toggle_n4");       endtask
    task automatic test_zero_vecs();    run_job(0, 2, 0, -1, -1, "zero_vecs");       endtask
    task automatic test_abort();
        run_job(5, 0, 1, T0 + 2, -1, "abort_stream");
        run_job(1, 0, 0, -1, -1, "after_abort_n1");
    endtask
    task automatic test_start_ignored(); run_job(3, 2, 0, -1, T0 + 1, "start_in_stream"); endtask
    task automatic test_reset_drain();   run_job(3, 0, 2, T0 + 7, -1, "reset_in_drain");  endtask
    task automatic test_idle_abort();    run_job(7, 0, 1, 0, -1, "abort_start_idle");     endtask
    task automatic test_random();
        for (int r = 0; r < 4; r++) run_job($urandom_range(1, 40), 2, 0, -1, -1, "random");
    endtask
    task automatic test_back_to_back();
        run_job(2, 0, 0, -1, -1, "b2b_a");
        run_job(1, 2, 0, -1, -1, "b2b_b");
    endtask
    task automatic test_max();           run_job(65535, 0, 0, -1, -1, "max_n");          endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_toggle();
        test_zero_vecs();
        test_abort();
        test_start_ignored();
        test_reset_drain();
        test_idle_abort();
        test_random();
        test_back_to_back();
        test_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
